// File: rtl/alarm_ctrl_multi_if.sv
// Sensor, programming and status bundle for alarm_ctrl_multi.
//   master: debouncers / programming host (drive inputs, observe outputs)
//   slave : alarm_ctrl_multi
//   Inputs : one_hz_enable, ignition, zones, reprogram, prog_sel, prog_val
//   Outputs: status, enable_siren, trigger_zone, bypass, timer_value,
//            state_display, arm_state_display
interface alarm_ctrl_multi_if #(
  parameter int unsigned N_ZONES = 4,
  parameter int unsigned CNT_W   = 6
);
  logic               one_hz_enable;
  logic               ignition;
  logic [N_ZONES-1:0] zones;
  logic               reprogram;
  logic [1:0]         prog_sel;
  logic [CNT_W-1:0]   prog_val;
  logic               status;
  logic               enable_siren;
  logic [N_ZONES-1:0] trigger_zone;
  logic [N_ZONES-1:0] bypass;
  logic [CNT_W-1:0]   timer_value;
  logic [2:0]         state_display;
  logic [1:0]         arm_state_display;

  modport master (
    output one_hz_enable, ignition, zones, reprogram, prog_sel, prog_val,
    input  status, enable_siren, trigger_zone, bypass, timer_value,
           state_display, arm_state_display
  );

  modport slave (
    input  one_hz_enable, ignition, zones, reprogram, prog_sel, prog_val,
    output status, enable_siren, trigger_zone, bypass, timer_value,
           state_display, arm_state_display
  );
endinterface

// File: rtl/alarm_ctrl_multi.sv
// Multi-zone vehicle alarm controller with built-in 1 Hz countdown timer,
// run-time programmable delays and a siren-duration limit with zone bypass.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : tick/ignition/zones/programming in; LED, siren, latched
//                  zones, bypass mask, countdown and state codes out
module alarm_ctrl_multi #(
  parameter int unsigned N_ZONES        = 4,
  parameter int unsigned CNT_W          = 6,
  parameter int unsigned T_ARM_DEF      = 6,
  parameter int unsigned T_DRIVER_DEF   = 8,
  parameter int unsigned T_PASS_DEF     = 15,
  parameter int unsigned T_ALARM_ON_DEF = 10,
  parameter int unsigned SIREN_MAX      = 30
) (
  input logic          clock,
  input logic          reset,
  alarm_ctrl_multi_if.slave bus
);

  localparam int unsigned SCNT_W = $clog2(SIREN_MAX + 1);

  typedef enum logic [2:0] {
    ST_SET     = 3'd0,
    ST_OFF     = 3'd1,
    ST_TRIGGER = 3'd2,
    ST_ON      = 3'd3,
    ST_STOP    = 3'd4
  } main_e;

  typedef enum logic [1:0] {
    AR_WAIT_IGN_OFF    = 2'd0,
    AR_WAIT_DOOR_OPEN  = 2'd1,
    AR_WAIT_DOOR_CLOSE = 2'd2,
    AR_START_DELAY     = 2'd3
  } arm_e;

  main_e              main_q, main_d;
  arm_e               arm_q, arm_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic               run_q, run_d;
  logic               status_q, status_d;
  logic               siren_q, siren_d;
  logic               blink_q, blink_d;
  logic [N_ZONES-1:0] trig_q, trig_d;
  logic [N_ZONES-1:0] byp_q, byp_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [CNT_W-1:0]   dly_q [4];
  logic [CNT_W-1:0]   dly_d [4];

  logic [N_ZONES-1:0] eff_c;
  logic               tick_c;
  logic               tmr_exp_c;
  logic               tmr_start_c;
  logic               tmr_stop_c;
  logic [CNT_W-1:0]   tmr_load_c;
  logic               arm_go_delay_c;
  logic               arm_go_close_c;

  assign tick_c    = bus.one_hz_enable;
  assign eff_c     = bus.zones & ~byp_q;
  // Expiry is the single tick that walks a running timer from 1 to 0.
  assign tmr_exp_c = run_q && tick_c && (tmr_q == CNT_W'(1));

  // Next-state, timer and output computation.
  always_comb begin
    main_d         = main_q;
    arm_d          = arm_q;
    tmr_d          = tmr_q;
    run_d          = run_q;
    trig_d         = trig_q;
    byp_d          = byp_q & bus.zones;   // bypass drops once its zone reads closed
    scnt_d         = scnt_q;
    dly_d          = dly_q;
    blink_d        = 1'b0;
    status_d       = 1'b0;
    siren_d        = 1'b0;
    tmr_start_c    = 1'b0;
    tmr_stop_c     = 1'b0;
    tmr_load_c     = '0;
    arm_go_delay_c = 1'b0;
    arm_go_close_c = 1'b0;

    // Arm sub-FSM runs independently of the main state.
    case (arm_q)
      AR_WAIT_IGN_OFF: begin
        if (!bus.ignition) arm_d = AR_WAIT_DOOR_OPEN;
      end
      AR_WAIT_DOOR_OPEN: begin
        if (bus.zones[0]) arm_d = AR_WAIT_DOOR_CLOSE;
      end
      AR_WAIT_DOOR_CLOSE: begin
        if (bus.ignition) begin
          arm_d = AR_WAIT_IGN_OFF;
        end else if (bus.zones == '0) begin
          arm_d          = AR_START_DELAY;
          arm_go_delay_c = 1'b1;
        end
      end
      AR_START_DELAY: begin
        if (bus.ignition) begin
          arm_d = AR_WAIT_IGN_OFF;
        end else if (bus.zones != '0) begin
          arm_d          = AR_WAIT_DOOR_CLOSE;
          arm_go_close_c = 1'b1;
        end
      end
    endcase

    // Main FSM: reprogram beats ignition beats normal sequencing.
    if (bus.reprogram) begin
      dly_d[bus.prog_sel] = bus.prog_val;
      main_d              = ST_SET;
      tmr_stop_c          = 1'b1;
      byp_d               = '0;
      scnt_d              = '0;
    end else if (bus.ignition) begin
      main_d     = ST_OFF;
      tmr_stop_c = 1'b1;
      byp_d      = '0;
    end else begin
      // The arm countdown only owns the timer while the main FSM sits in OFF.
      if (main_q == ST_OFF && arm_go_delay_c) begin
        tmr_start_c = 1'b1;
        tmr_load_c  = dly_q[0];
      end
      if (main_q == ST_OFF && arm_go_close_c) tmr_stop_c = 1'b1;

      case (main_q)
        ST_SET: begin
          if (eff_c != '0) begin
            main_d      = ST_TRIGGER;
            tmr_start_c = 1'b1;
            tmr_load_c  = eff_c[0] ? dly_q[1] : dly_q[2];
            trig_d      = eff_c;
          end
        end
        ST_TRIGGER: begin
          if (tmr_exp_c) begin
            main_d = ST_ON;
            scnt_d = '0;
          end
        end
        ST_ON, ST_STOP: begin
          if (tick_c) scnt_d = scnt_q + SCNT_W'(1);
          if (tick_c && (scnt_q == SCNT_W'(SIREN_MAX - 1))) begin
            // Siren ran too long: rearm and mask zones that are stuck open.
            main_d     = ST_SET;
            byp_d      = byp_d | bus.zones;
            tmr_stop_c = 1'b1;
          end else if (main_q == ST_ON) begin
            if (eff_c == '0) begin
              main_d      = ST_STOP;
              tmr_start_c = 1'b1;
              tmr_load_c  = dly_q[3];
            end
          end else if (eff_c != '0) begin
            main_d     = ST_ON;
            tmr_stop_c = 1'b1;
          end else if (tmr_exp_c) begin
            main_d = ST_SET;
          end
        end
        ST_OFF: begin
          if ((arm_q == AR_START_DELAY) && tmr_exp_c) main_d = ST_SET;
        end
        default: main_d = ST_SET;
      endcase
    end

    if (main_d == ST_SET || main_d == ST_OFF) trig_d = '0;

    // Countdown: load beats stop beats decrement; a zero delay loads 1.
    if (tmr_start_c) begin
      tmr_d = (tmr_load_c == '0) ? CNT_W'(1) : tmr_load_c;
      run_d = 1'b1;
    end else if (tmr_stop_c) begin
      run_d = 1'b0;
    end else if (run_q && tick_c) begin
      tmr_d = tmr_q - CNT_W'(1);
      if (tmr_q == CNT_W'(1)) run_d = 1'b0;
    end

    // Blink only advances on ticks spent in SET; it restarts at 0 on entry.
    blink_d  = (main_d == ST_SET) ? (blink_q ^ (tick_c && (main_q == ST_SET))) : 1'b0;
    status_d = (main_d == ST_SET) ? blink_d : (main_d != ST_OFF);
    siren_d  = (main_d == ST_ON) || (main_d == ST_STOP);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q   <= ST_SET;
      arm_q    <= AR_WAIT_IGN_OFF;
      tmr_q    <= '0;
      run_q    <= 1'b0;
      status_q <= 1'b0;
      siren_q  <= 1'b0;
      blink_q  <= 1'b0;
      trig_q   <= '0;
      byp_q    <= '0;
      scnt_q   <= '0;
      dly_q[0] <= CNT_W'(T_ARM_DEF);
      dly_q[1] <= CNT_W'(T_DRIVER_DEF);
      dly_q[2] <= CNT_W'(T_PASS_DEF);
      dly_q[3] <= CNT_W'(T_ALARM_ON_DEF);
    end else begin
      main_q   <= main_d;
      arm_q    <= arm_d;
      tmr_q    <= tmr_d;
      run_q    <= run_d;
      status_q <= status_d;
      siren_q  <= siren_d;
      blink_q  <= blink_d;
      trig_q   <= trig_d;
      byp_q    <= byp_d;
      scnt_q   <= scnt_d;
      dly_q    <= dly_d;
    end
  end

  assign bus.status            = status_q;
  assign bus.enable_siren      = siren_q;
  assign bus.trigger_zone      = trig_q;
  assign bus.bypass            = byp_q;
  assign bus.timer_value       = tmr_q;
  assign bus.state_display     = main_q;
  assign bus.arm_state_display = arm_q;

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Directed-plus-randomized bench for alarm_ctrl_multi. Expected values come
// from the delay table kept here and simple countdown arithmetic.
module tb_alarm_ctrl_multi;
  localparam int unsigned NZ = 4;
  localparam int unsigned CW = 6;
  localparam int unsigned S_SET = 0, S_OFF = 1, S_TRIG = 2, S_ON = 3, S_STOP = 4;

  logic clock = 1'b0;
  logic reset;

  alarm_ctrl_multi_if #(.N_ZONES(NZ), .CNT_W(CW)) bus ();
  alarm_ctrl_multi #(.N_ZONES(NZ), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural delay table: tracks defaults and reprogrammed values.
  int unsigned d_arm = 6, d_drv = 8, d_pass = 15, d_aon = 10;
  int unsigned n_pass = 0, n_total = 0, n_fail = 0;

  function automatic int unsigned load_of(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned entry_delay(input logic [NZ-1:0] eff);
    return load_of(eff[0] ? d_drv : d_pass);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One tick, preceded by 0..2 idle cycles when rand_gap is set.
  task automatic tick(input bit rand_gap);
    int unsigned gap;
    gap = rand_gap ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < int'(gap); i++) step();
    bus.one_hz_enable = 1'b1;
    step();
    bus.one_hz_enable = 1'b0;
  endtask

  task automatic check_main(input string tag, input int unsigned st);
    chk({tag, ".state"}, 32'(bus.state_display), st);
    chk({tag, ".siren"}, 32'(bus.enable_siren), (st == S_ON || st == S_STOP) ? 1 : 0);
    if (st != S_SET) chk({tag, ".status"}, 32'(bus.status), (st == S_OFF) ? 0 : 1);
  endtask

  initial begin
    logic [NZ-1:0] zm;
    int unsigned   v;

    reset = 1'b1;
    bus.one_hz_enable = 1'b0;
    bus.ignition      = 1'b0;
    bus.zones         = '0;
    bus.reprogram     = 1'b0;
    bus.prog_sel      = '0;
    bus.prog_val      = '0;
    step();
    step();

    // Reset values
    check_main("rst", S_SET);
    chk("rst.status", 32'(bus.status), 0);
    chk("rst.arm", 32'(bus.arm_state_display), 0);
    chk("rst.timer", 32'(bus.timer_value), 0);
    chk("rst.trig", 32'(bus.trigger_zone), 0);
    chk("rst.bypass", 32'(bus.bypass), 0);

    // Driver door triggers, entry countdown, alarm on
    reset = 1'b0;
    bus.zones = 4'b0001;
    step();
    check_main("t1.trig", S_TRIG);
    chk("t1.tzone", 32'(bus.trigger_zone), 1);
    chk("t1.timer", 32'(bus.timer_value), entry_delay(4'b0001));
    for (int k = 1; k <= int'(d_drv); k++) begin
      tick(1'b1);
      if (k < int'(d_drv)) chk("t1.count", 32'(bus.timer_value), d_drv - k);
      else check_main("t1.on", S_ON);
    end

    // Close, reopen during hold-off, close and time out
    bus.zones = 4'b0000;
    step();
    check_main("t2.stop", S_STOP);
    chk("t2.timer", 32'(bus.timer_value), load_of(d_aon));
    for (int k = 1; k <= 4; k++) tick(1'b1);
    chk("t2.count4", 32'(bus.timer_value), d_aon - 4);
    bus.zones = 4'b0100;
    tick(1'b0);
    check_main("t2.reopen", S_ON);
    bus.zones = 4'b0000;
    step();
    check_main("t2.stop2", S_STOP);
    chk("t2.timer2", 32'(bus.timer_value), load_of(d_aon));
    for (int k = 1; k <= int'(d_aon); k++) begin
      tick(1'b1);
      if (k < int'(d_aon)) check_main("t2.hold", S_STOP);
    end
    check_main("t2.set", S_SET);
    chk("t2.status0", 32'(bus.status), 0);
    tick(1'b1);
    chk("t2.blink1", 32'(bus.status), 1);
    tick(1'b1);
    chk("t2.blink0", 32'(bus.status), 0);

    // Arming sequence with interruption
    bus.ignition = 1'b1;
    step();
    check_main("t3.off", S_OFF);
    chk("t3.arm0", 32'(bus.arm_state_display), 0);
    bus.ignition = 1'b0;
    step();
    chk("t3.arm1", 32'(bus.arm_state_display), 1);
    bus.zones = 4'b0001;
    step();
    chk("t3.arm2", 32'(bus.arm_state_display), 2);
    bus.zones = 4'b0000;
    step();
    chk("t3.arm3", 32'(bus.arm_state_display), 3);
    chk("t3.timer", 32'(bus.timer_value), load_of(d_arm));
    for (int k = 1; k <= 3; k++) tick(1'b1);
    chk("t3.count3", 32'(bus.timer_value), d_arm - 3);
    bus.zones = 4'b0100;
    step();
    chk("t3.back2", 32'(bus.arm_state_display), 2);
    tick(1'b1);
    tick(1'b1);
    chk("t3.frozen", 32'(bus.timer_value), d_arm - 3);
    check_main("t3.stilloff", S_OFF);
    bus.zones = 4'b0000;
    step();
    chk("t3.restart", 32'(bus.timer_value), load_of(d_arm));
    for (int k = 1; k <= int'(d_arm); k++) begin
      tick(1'b1);
      if (k < int'(d_arm)) check_main("t3.arming", S_OFF);
    end
    check_main("t3.set", S_SET);
    chk("t3.status", 32'(bus.status), 0);

    // Stuck-open passenger zone hits the siren limit and is bypassed
    zm = 4'(($urandom_range(1, 7)) << 1);
    bus.zones = zm;
    step();
    check_main("t4.trig", S_TRIG);
    chk("t4.timer", 32'(bus.timer_value), entry_delay(zm));
    chk("t4.tzone", 32'(bus.trigger_zone), 32'(zm));
    for (int k = 1; k <= int'(d_pass); k++) tick(1'b1);
    check_main("t4.on", S_ON);
    for (int k = 1; k <= 30; k++) begin
      tick(1'b1);
      if (k < 30) check_main("t4.siren", S_ON);
    end
    check_main("t4.limit", S_SET);
    chk("t4.bypass", 32'(bus.bypass), 32'(zm));
    chk("t4.tzclr", 32'(bus.trigger_zone), 0);
    step();
    check_main("t4.noretrig", S_SET);
    bus.zones = 4'b0000;
    step();
    chk("t4.bypclr", 32'(bus.bypass), 0);
    bus.zones = zm;
    step();
    check_main("t4.retrig", S_TRIG);
    chk("t4.timer2", 32'(bus.timer_value), entry_delay(zm));

    // Reprogram the driver delay from TRIGGER
    v = $urandom_range(1, 20);
    bus.reprogram = 1'b1;
    bus.prog_sel  = 2'd1;
    bus.prog_val  = CW'(v);
    bus.zones     = 4'b0000;
    step();
    bus.reprogram = 1'b0;
    d_drv = v;
    check_main("t5.set", S_SET);
    chk("t5.status", 32'(bus.status), 0);
    chk("t5.tzone", 32'(bus.trigger_zone), 0);
    tick(1'b1);
    chk("t5.held", 32'(bus.timer_value), entry_delay(zm));
    chk("t5.blink", 32'(bus.status), 1);
    bus.zones = 4'b0001;
    step();
    check_main("t5.trig", S_TRIG);
    chk("t5.timer", 32'(bus.timer_value), entry_delay(4'b0001));
    for (int k = 1; k <= int'(d_drv); k++) tick(1'b1);
    check_main("t5.on", S_ON);
    tick(1'b1);
    tick(1'b1);

    // Reset mid-siren restores everything, including delays
    bus.zones = 4'b0000;
    reset = 1'b1;
    step();
    d_arm = 6; d_drv = 8; d_pass = 15; d_aon = 10;
    check_main("rst2", S_SET);
    chk("rst2.status", 32'(bus.status), 0);
    chk("rst2.timer", 32'(bus.timer_value), 0);
    chk("rst2.arm", 32'(bus.arm_state_display), 0);
    reset = 1'b0;
    bus.zones = 4'b0001;
    step();
    chk("rst2.defdly", 32'(bus.timer_value), entry_delay(4'b0001));

    // Zero arm delay expires after a single tick
    bus.reprogram = 1'b1;
    bus.prog_sel  = 2'd0;
    bus.prog_val  = '0;
    bus.zones     = 4'b0000;
    step();
    bus.reprogram = 1'b0;
    d_arm = 0;
    check_main("t6.set", S_SET);
    bus.ignition = 1'b1;
    step();
    bus.ignition = 1'b0;
    step();
    chk("t6.arm1", 32'(bus.arm_state_display), 1);
    bus.zones = 4'b0001;
    step();
    bus.zones = 4'b0000;
    step();
    chk("t6.arm3", 32'(bus.arm_state_display), 3);
    chk("t6.timer1", 32'(bus.timer_value), load_of(d_arm));
    tick(1'b0);
    check_main("t6.armed", S_SET);

    // Arm countdown started on the same cycle as a tick keeps the full value
    v = $urandom_range(2, 9);
    bus.reprogram = 1'b1;
    bus.prog_val  = CW'(v);
    step();
    bus.reprogram = 1'b0;
    d_arm = v;
    bus.ignition = 1'b1;
    step();
    bus.ignition = 1'b0;
    step();
    bus.zones = 4'b0001;
    step();
    chk("t6b.arm2", 32'(bus.arm_state_display), 2);
    bus.zones = 4'b0000;
    tick(1'b0);
    chk("t6b.load", 32'(bus.timer_value), load_of(d_arm));
    for (int k = 1; k <= int'(d_arm); k++) begin
      tick(1'b1);
      if (k < int'(d_arm)) chk("t6b.count", 32'(bus.timer_value), d_arm - k);
    end
    check_main("t6b.set", S_SET);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
